alu_muldiv_seq: RTL and testbench



---
 rtl/alu_muldiv_seq.sv | 146 ++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// RV32M multiply/divide: one shift-add or restoring-divide bit per cycle, W+1 cycles accept-to-valid (1 for fast path).
// Accepts only while idle; a finished result is held in DONE until out_ready, so the issuing stage stalls on busy.
module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = $clog2(DATA_WIDTH) + 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [2:0]            Funct3,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] MDResult,
    output logic                  busy
);
    localparam int W = DATA_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [2:0]           funct3_q, funct3_d;
    logic [W-1:0]         addend_q, addend_d;
    logic [2*W-1:0]       acc_q, acc_d;
    logic                 neg_q, neg_d;
    logic [W-1:0]         result_q, result_d;
    logic                 out_valid_q, out_valid_d;

    logic           accept, is_div_in, a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic           div_zero, div_ovf, mul_zero, fast;
    logic [W-1:0]   a_mag, b_mag, fast_res;
    logic [W:0]     mul_sum, div_shift, div_diff;
    logic [2*W-1:0] mul_step, div_step, acc_nxt, prod_fix;
    logic [W-1:0]   div_sel, div_fix, mul_sel, final_res;

    assign in_ready  = (state_q == IDLE) & ~reset;
    assign accept    = in_valid & in_ready;
    assign out_valid = out_valid_q;
    assign MDResult  = result_q;
    assign busy      = (state_q != IDLE);

    // Operand decode: MUL is treated as signed; its low half is identical either way.
    assign is_div_in = Funct3[2];
    assign a_sgn_in  = (Funct3 != 3'b011) & (Funct3 != 3'b101) & (Funct3 != 3'b111);
    assign b_sgn_in  = a_sgn_in & (Funct3 != 3'b010);
    assign a_neg_in  = a_sgn_in & SrcA[W-1];
    assign b_neg_in  = b_sgn_in & SrcB[W-1];
    assign a_mag     = a_neg_in ? -SrcA : SrcA;
    assign b_mag     = b_neg_in ? -SrcB : SrcB;

    assign div_zero = is_div_in & (SrcB == '0);
    assign div_ovf  = ((Funct3 == 3'b100) | (Funct3 == 3'b110)) & (SrcA == MIN_VAL) & (SrcB == '1);
    assign mul_zero = ~is_div_in & ((SrcA == '0) | (SrcB == '0));
    assign fast     = div_zero | div_ovf | mul_zero;
    assign fast_res = div_zero ? (Funct3[1] ? SrcA : '1) :
                      div_ovf  ? (Funct3[1] ? '0 : MIN_VAL) : '0;

    // Multiply: {partial product, remaining multiplier bits} shifts right each step.
    assign mul_sum  = {1'b0, acc_q[2*W-1:W]} + {1'b0, addend_q};
    assign mul_step = acc_q[0] ? {mul_sum, acc_q[W-1:1]} : {1'b0, acc_q[2*W-1:1]};

    // Divide: {remainder, dividend/quotient} shifts left; quotient bits enter at the bottom.
    assign div_shift = {acc_q[2*W-1:W], acc_q[W-1]};
    assign div_diff  = div_shift - {1'b0, addend_q};
    assign div_step  = div_diff[W] ? {div_shift[W-1:0], acc_q[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc_q[W-2:0], 1'b1};

    assign acc_nxt   = funct3_q[2] ? div_step : mul_step;
    assign prod_fix  = neg_q ? -acc_nxt : acc_nxt;
    assign mul_sel   = (funct3_q[1:0] == 2'b00) ? prod_fix[W-1:0] : prod_fix[2*W-1:W];
    assign div_sel   = funct3_q[1] ? acc_nxt[2*W-1:W] : acc_nxt[W-1:0];
    assign div_fix   = neg_q ? -div_sel : div_sel;
    assign final_res = funct3_q[2] ? div_fix : mul_sel;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        funct3_d    = funct3_q;
        addend_d    = addend_q;
        acc_d       = acc_q;
        neg_d       = neg_q;
        result_d    = result_q;
        out_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    funct3_d = Funct3;
                    cnt_d    = '0;
                    neg_d    = (Funct3[2] & Funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);
                    addend_d = is_div_in ? b_mag : a_mag;
                    acc_d    = is_div_in ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                    if (fast) begin
                        result_d = fast_res;
                        state_d  = DONE;
                    end else begin
                        state_d  = CALC;
                    end
                end
            end
            CALC: begin
                acc_d = acc_nxt;
                cnt_d = cnt_q + CNT_WIDTH'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d = final_res;
                    state_d  = DONE;
                end
            end
            DONE: begin
                // out_valid trails DONE entry by one cycle; the handshake only counts once it is up.
                if (out_valid_q & out_ready) begin
                    state_d = IDLE;
                end else begin
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            funct3_q    <= '0;
            addend_q    <= '0;
            acc_q       <= '0;
            neg_q       <= 1'b0;
            result_q    <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            funct3_q    <= funct3_d;
            addend_q    <= addend_d;
            acc_q       <= acc_d;
            neg_q       <= neg_d;
            result_q    <= result_d;
            out_valid_q <= out_valid_d;
        end
    end
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: latency, RV32M results, fast paths, hold, reset abort.
module tb_alu_muldiv_seq;
    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  Funct3;
    logic [31:0] SrcA;
    logic [31:0] SrcB;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] MDResult;
    logic        busy;

    int errors = 0;
    int checks = 0;

    localparam logic [2:0] F_MUL = 3'b000, F_MULH = 3'b001, F_MULHSU = 3'b010, F_MULHU = 3'b011;
    localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

    alu_muldiv_seq #(.DATA_WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Funct3    (Funct3),
        .SrcA      (SrcA),
        .SrcB      (SrcB),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .MDResult  (MDResult),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Issue one op while idle, wait (bounded) for out_valid, capture result and handshake it.
    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
        Funct3 = f3; SrcA = a; SrcB = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; SrcA = 32'hDEAD_BEEF; SrcB = 32'h1234_5678; Funct3 = 3'b000;
        lat = 0;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = MDResult;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; Funct3 = F_DIVU; SrcA = 32'd9; SrcB = 32'd3; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || MDResult !== 32'h0) begin
            errors++; $display("FAIL reset_state: out_valid=%b busy=%b MDResult=%h want 0/0/0", out_valid, busy, MDResult);
        end
        reset = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_release: in_ready=%b busy=%b want 1/0", in_ready, busy);
        end
    endtask

    task automatic test_mul_basic();
        int  lat;
        bit  ready_bad;
        Funct3 = F_MUL; SrcA = 32'd7; SrcB = 32'hFFFF_FFFD; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; SrcA = 32'h0; SrcB = 32'h0;
        lat = 0; ready_bad = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) ready_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        checks++;
        if (ready_bad) begin errors++; $display("FAIL mul_calc_ready: in_ready high or busy low during CALC"); end
        checks++;
        if (lat != 33) begin errors++; $display("FAIL mul_latency: got %0d want 33", lat); end
        checks++;
        if (MDResult !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mul_7x-3: got %h want ffffffeb", MDResult); end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL mul_handshake: out_valid=%b in_ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_vectors();
        logic [2:0]  f3  [11];
        logic [31:0] va  [11];
        logic [31:0] vb  [11];
        logic [31:0] exp_r [11];
        int          exp_l [11];
        logic [31:0] res;
        int          lat;
        f3[0]  = F_MULH;   va[0]  = 32'h8000_0000; vb[0]  = 32'h8000_0000; exp_r[0]  = 32'h4000_0000; exp_l[0]  = 33;
        f3[1]  = F_MULHU;  va[1]  = 32'hFFFF_FFFF; vb[1]  = 32'hFFFF_FFFF; exp_r[1]  = 32'hFFFF_FFFE; exp_l[1]  = 33;
        f3[2]  = F_MULHSU; va[2]  = 32'hFFFF_FFFF; vb[2]  = 32'hFFFF_FFFF; exp_r[2]  = 32'hFFFF_FFFF; exp_l[2]  = 33;
        f3[3]  = F_DIV;    va[3]  = 32'hFFFF_FFF9; vb[3]  = 32'd2;         exp_r[3]  = 32'hFFFF_FFFD; exp_l[3]  = 33;
        f3[4]  = F_REM;    va[4]  = 32'hFFFF_FFF9; vb[4]  = 32'd2;         exp_r[4]  = 32'hFFFF_FFFF; exp_l[4]  = 33;
        f3[5]  = F_DIVU;   va[5]  = 32'd100;       vb[5]  = 32'd7;         exp_r[5]  = 32'd14;        exp_l[5]  = 33;
        f3[6]  = F_REMU;   va[6]  = 32'd100;       vb[6]  = 32'd7;         exp_r[6]  = 32'd2;         exp_l[6]  = 33;
        f3[7]  = F_DIVU;   va[7]  = 32'd5;         vb[7]  = 32'd0;         exp_r[7]  = 32'hFFFF_FFFF; exp_l[7]  = 1;
        f3[8]  = F_REMU;   va[8]  = 32'd5;         vb[8]  = 32'd0;         exp_r[8]  = 32'd5;         exp_l[8]  = 1;
        f3[9]  = F_DIV;    va[9]  = 32'h8000_0000; vb[9]  = 32'hFFFF_FFFF; exp_r[9]  = 32'h8000_0000; exp_l[9]  = 1;
        f3[10] = F_REM;    va[10] = 32'h8000_0000; vb[10] = 32'hFFFF_FFFF; exp_r[10] = 32'h0;         exp_l[10] = 1;
        for (int i = 0; i < 11; i++) begin
            run_op(f3[i], va[i], vb[i], res, lat);
            checks++;
            if (res !== exp_r[i]) begin
                errors++; $display("FAIL vec%0d_result f3=%0d a=%h b=%h: got %h want %h", i, f3[i], va[i], vb[i], res, exp_r[i]);
            end
            checks++;
            if (lat != exp_l[i]) begin
                errors++; $display("FAIL vec%0d_latency: got %0d want %0d", i, lat, exp_l[i]);
            end
        end
    endtask

    task automatic test_mul_zero();
        logic [31:0] res;
        int          lat;
        run_op(F_MULH, 32'h0, 32'hFFFF_FFFF, res, lat);
        checks++;
        if (res !== 32'h0 || lat != 1) begin
            errors++; $display("FAIL mul_zero_fast: got %h lat %0d want 0 lat 1", res, lat);
        end
    endtask

    task automatic test_hold();
        int  lat;
        bit  hold_bad;
        Funct3 = F_DIVU; SrcA = 32'd100; SrcB = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (lat != 33 || MDResult !== 32'd14) begin
            errors++; $display("FAIL hold_setup: lat %0d result %h want 33 / 0000000e", lat, MDResult);
        end
        hold_bad = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0]; Funct3 = F_MUL; SrcA = 32'd3; SrcB = 32'd3;
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || MDResult !== 32'd14 || in_ready !== 1'b0) hold_bad = 1'b1;
        end
        checks++;
        if (hold_bad) begin errors++; $display("FAIL hold_stable: out_valid/MDResult/in_ready changed while stalled"); end
        in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release: in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        Funct3 = F_DIVU; SrcA = 32'd9; SrcB = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++; $display("FAIL hold_next_accept: busy=%b in_ready=%b want 1/0", busy, in_ready);
        end
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        checks++;
        if (MDResult !== 32'd3 || lat != 33) begin
            errors++; $display("FAIL hold_next_result: got %h lat %0d want 3 lat 33", MDResult, lat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        int          lat;
        bit          ghost;
        Funct3 = F_MULHU; SrcA = 32'hFFFF_FFFF; SrcB = 32'h0000_1234; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (15) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0 || MDResult !== 32'h0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_mid_state: busy=%b out_valid=%b MDResult=%h in_ready=%b want 0/0/0/0",
                               busy, out_valid, MDResult, in_ready);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b want 1", in_ready); end
        ghost = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid !== 1'b0 || busy !== 1'b0) ghost = 1'b1;
        end
        checks++;
        if (ghost) begin errors++; $display("FAIL reset_mid_abort: aborted op produced activity"); end
        run_op(F_DIVU, 32'd9, 32'd3, res, lat);
        checks++;
        if (res !== 32'd3 || lat != 33) begin
            errors++; $display("FAIL reset_mid_next: got %h lat %0d want 3 lat 33", res, lat);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r1, r2;
        int          l1, l2;
        run_op(F_REM, 32'd17, 32'hFFFF_FFFB, r1, l1);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready: got %b want 1", in_ready); end
        run_op(F_DIV, 32'hFFFF_FFEF, 32'hFFFF_FFFB, r2, l2);
        checks++;
        if (r1 !== 32'd2 || l1 != 33) begin errors++; $display("FAIL b2b_rem: got %h lat %0d want 2 lat 33", r1, l1); end
        checks++;
        if (r2 !== 32'd3 || l2 != 33) begin errors++; $display("FAIL b2b_div: got %h lat %0d want 3 lat 33", r2, l2); end
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        Funct3 = 3'b000; SrcA = 32'h0; SrcB = 32'h0;
        @(posedge clk); #1;
        test_reset();
        test_mul_basic();
        test_vectors();
        test_mul_zero();
        test_hold();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
